pi_digit_extractor: RTL

- Downstream consumer of the Leibniz pi accumulator.
- Takes the accumulator's unsigned fixed-point result (Q4.48: 4 integer bits, 48 fraction bits) and emits decimal digits serially: the integer digit first, then NDIGITS fraction digits.
- Each digit is delivered over a valid/ready handshake to the board display/LCD driver.
- Fraction digits come from a repeated multiply-by-10, one digit per accepted transfer.

---
 rtl/pi_display_pkg.sv | 33 +++
 rtl/seg7_decoder.sv | 21 ++
 rtl/pi_digit_extractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pi_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_display_pkg
// Description : Shared types and constants for the pi digit display path.
//               Holds the extractor FSM state type, default fixed-point
//               geometry, the integer-overflow digit code and the 7-segment
//               glyph table (bit0 = segment a ... bit6 = segment g, bit7 = dp).
// Revision    : 1.0 - initial release
// ============================================================================
package pi_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FRAC_BITS_DEF = 48;
    localparam int INT_BITS_DEF  = 4;

    // Shown in place of the integer digit when the integer part exceeds 9.
    localparam logic [3:0] DIGIT_OVF = 4'hF;

    // Glyphs for 0..F packed LSB-first: entry n lives at [n*8 +: 8].
    // Bit 7 (decimal point) is always clear here; the decoder adds it.
    localparam logic [127:0] SEG7_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage : pi_display_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational hex-to-7-segment decoder with decimal point.
// Ports       : digit   [3:0] in  - hex digit to display
//               dp            in  - decimal point request
//               pattern [7:0] out - {dp, g, f, e, d, c, b, a}, active high
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import pi_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {dp, SEG7_TABLE[{digit, 3'b000} +: 7]};

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/pi_digit_extractor.sv
`default_nettype none
// ============================================================================
// Module      : pi_digit_extractor
// Description : Converts an unsigned Q(INT_BITS).(FRAC_BITS) value into
//               decimal digits, integer digit first, then NDIGITS fraction
//               digits, each offered over a valid/ready handshake.
//               Fraction digits come from repeated multiply-by-10 with
//               truncation.
// Ports       : clk_2        in   system clock
//               reset        in   synchronous active-high reset
//               start        in   conversion request, honoured only when idle
//               value        in   fixed-point number to convert
//               digit_ready  in   consumer accepts the current digit
//               digit_valid  out  digit/digit_idx valid
//               digit        out  BCD digit, 4'hF for integer overflow
//               digit_idx    out  0 = integer digit, 1..NDIGITS = fraction
//               busy         out  conversion in progress
//               done         out  one-cycle pulse after the last transfer
//               int_ovf      out  integer part > 9, held until next start
//               seg          out  7-segment pattern of the current digit
// Options     : SEG7_DISPLAY_EN - drive seg from a 7-segment decoder;
//               when undefined, seg is tied to 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_digit_extractor
    import pi_display_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int INT_BITS  = INT_BITS_DEF,
    parameter int NDIGITS   = 8
) (
    input  logic                             clk_2,
    input  logic                             reset,
    input  logic                             start,
    input  logic [INT_BITS+FRAC_BITS-1:0]    value,
    input  logic                             digit_ready,
    output logic                             digit_valid,
    output logic [3:0]                       digit,
    output logic [$clog2(NDIGITS+1)-1:0]     digit_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             int_ovf,
    output logic [7:0]                       seg
);

    localparam int                IDX_W    = $clog2(NDIGITS+1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDIGITS);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t                 state;
    logic [FRAC_BITS-1:0]   frac_q;

    // Integer part widened so the "> 9" test works for any INT_BITS.
    logic [31:0]            int_wide;
    logic                   int_is_ovf;
    logic [3:0]             int_digit;

    assign int_wide   = 32'(value[INT_BITS+FRAC_BITS-1:FRAC_BITS]);
    assign int_is_ovf = (int_wide > 32'd9);
    assign int_digit  = int_is_ovf ? DIGIT_OVF : int_wide[3:0];

    // frac * 10 as shift-and-add; the top four bits are the next decimal
    // digit (always 0..9 since frac < 1), the rest is the new remainder.
    logic [FRAC_BITS+3:0]   prod;
    logic [3:0]             step_digit;
    logic [FRAC_BITS-1:0]   step_frac;

    assign prod       = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);
    assign step_digit = prod[FRAC_BITS+3:FRAC_BITS];
    assign step_frac  = prod[FRAC_BITS-1:0];

    logic transfer;
    assign transfer = digit_valid && digit_ready;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state       <= IDLE;
            frac_q      <= '0;
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            digit_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            int_ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frac_q      <= value[FRAC_BITS-1:0];
                        int_ovf     <= int_is_ovf;
                        digit       <= int_digit;
                        digit_idx   <= '0;
                        digit_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= INT;
                    end
                end
                INT: begin
                    if (transfer) begin
                        digit     <= step_digit;
                        frac_q    <= step_frac;
                        digit_idx <= IDX_ONE;
                        state     <= FRAC;
                    end
                end
                FRAC: begin
                    if (transfer) begin
                        if (digit_idx == LAST_IDX) begin
                            digit_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            digit     <= step_digit;
                            frac_q    <= step_frac;
                            digit_idx <= digit_idx + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEG7_DISPLAY_EN
    logic [7:0] seg_raw;

    seg7_decoder u_seg7_decoder (
        .digit   (digit),
        .dp      (digit_idx == '0),
        .pattern (seg_raw)
    );

    assign seg = digit_valid ? seg_raw : 8'h00;
`else
    assign seg = 8'h00;
`endif

endmodule : pi_digit_extractor
`default_nettype wire
